// File: rtl/nfc_axis_pattern_engine_pkg.sv
// Shared definitions for the NFC test-data pattern engine.
//   LFSR_POLY      Galois LFSR feedback polynomial (right-shifting form)
//   LFSR_ZERO_SUB  value used instead of an all-zero LFSR seed
//   ST_IDLE/ST_RUN/ST_DONE  FSM encodings shared by generator and checker
//   keep_for_len() tkeep of the final beat from the low two bits of a byte length
//   lfsr_next()    one Galois LFSR step
package nfc_test_pkg;

  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] LFSR_ZERO_SUB = 32'h0000_0001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // len % 4 == 0 means the final beat is full.
  function automatic logic [3:0] keep_for_len(input logic [1:0] len_lo);
    case (len_lo)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] w);
    return (w >> 1) ^ (w[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/nfc_axis_pattern_engine_if.sv
// AXI-Stream bundle used for both the write (generator) and read (checker) streams.
//   master modport: drives tvalid/tdata/tkeep/tlast/tid/tuser, receives tready
//   slave modport:  receives the payload, drives tready
interface nfc_axis_pattern_engine_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic [15:0] tid;
  logic [3:0]  tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tid, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tid, tuser, output tready);
endinterface

// File: rtl/nfc_axis_pattern_engine_word.sv
// Pattern word sequencer: holds pattern(i) for the current beat.
//   clk, rst  clock and synchronous active-high reset
//   load      capture seed as pattern(0)
//   seed      pattern seed
//   adv       step to pattern(i+1)
//   word      current pattern word
// Build option PATTERN_LFSR_EN selects a Galois LFSR sequence; otherwise
// the sequence is an incrementing counter starting at the seed.
module nfc_pattern_word
  import nfc_test_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] word
);

  logic [31:0] word_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg <= '0;
    end else if (load) begin
`ifdef PATTERN_LFSR_EN
      // An all-zero LFSR would lock up, so substitute a nonzero start.
      word_reg <= (seed == 32'h0) ? LFSR_ZERO_SUB : seed;
`else
      word_reg <= seed;
`endif
    end else if (adv) begin
`ifdef PATTERN_LFSR_EN
      word_reg <= lfsr_next(word_reg);
`else
      word_reg <= word_reg + 32'd1;
`endif
    end
  end

  assign word = word_reg;

endmodule

// File: rtl/nfc_axis_pattern_engine.sv
// Test-data engine beside the NFC channel: a generator producing seed-derived
// page data on an AXI-Stream master, and an independent checker comparing an
// AXI-Stream slave against the same pattern.
//   nand_usr_clk, nand_usr_rst       clock, synchronous active-high reset
//   gen_start/gen_seed/gen_len       start a write stream of gen_len bytes
//   gen_busy, gen_done               generator running / final beat accepted pulse
//   m_axis (master)                  write stream to the channel
//   chk_start/chk_seed/chk_len       arm the checker for chk_len bytes
//   s_axis (slave)                   read stream from the channel (tid ignored)
//   chk_busy, chk_done               checker armed / check finished pulse
//   chk_err_cnt                      mismatching beats, saturating
//   chk_first_err                    first mismatching beat index, all-ones = none
//   chk_len_err                      tlast early or missing
//   chk_user_flag                    some accepted beat had nonzero tuser
// Build option PATTERN_LFSR_EN selects the LFSR pattern (see nfc_pattern_word).
module nfc_axis_pattern_engine
  import nfc_test_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 24
) (
  input  logic                   nand_usr_clk,
  input  logic                   nand_usr_rst,
  input  logic                   gen_start,
  input  logic [31:0]            gen_seed,
  input  logic [LEN_W-1:0]       gen_len,
  output logic                   gen_busy,
  output logic                   gen_done,
  nfc_axis_pattern_engine_if.master m_axis,
  input  logic                   chk_start,
  input  logic [31:0]            chk_seed,
  input  logic [LEN_W-1:0]       chk_len,
  nfc_axis_pattern_engine_if.slave  s_axis,
  output logic                   chk_busy,
  output logic                   chk_done,
  output logic [LEN_W-1:0]       chk_err_cnt,
  output logic [LEN_W-1:0]       chk_first_err,
  output logic                   chk_len_err,
  output logic                   chk_user_flag
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  // ---------------- generator ----------------
  logic [1:0]       gen_state_reg;
  logic [LEN_W-1:0] gen_cnt_reg;
  logic [LEN_W-1:0] gen_last_reg;   // index of the final beat
  logic [3:0]       gen_keep_reg;   // tkeep of the final beat
  logic [31:0]      gen_word;
  logic             gen_run;
  logic             gen_is_last;
  logic             gen_fire;
  logic             gen_load;

  assign gen_run     = (gen_state_reg == ST_RUN);
  assign gen_is_last = (gen_cnt_reg == gen_last_reg);
  assign gen_fire    = gen_run && m_axis.tready;
  assign gen_load    = (gen_state_reg == ST_IDLE) && gen_start;

  nfc_pattern_word u_gen_word (
    .clk  (nand_usr_clk),
    .rst  (nand_usr_rst),
    .load (gen_load),
    .seed (gen_seed),
    .adv  (gen_fire),
    .word (gen_word)
  );

  always_ff @(posedge nand_usr_clk) begin
    if (nand_usr_rst) begin
      gen_state_reg <= ST_IDLE;
      gen_cnt_reg   <= '0;
      gen_last_reg  <= '0;
      gen_keep_reg  <= '0;
    end else begin
      case (gen_state_reg)
        ST_IDLE: begin
          if (gen_start) begin
            gen_cnt_reg   <= '0;
            // (len-1)/4 equals ceil(len/4)-1 for any nonzero len.
            gen_last_reg  <= (gen_len - LEN_ONE) >> 2;
            gen_keep_reg  <= keep_for_len(gen_len[1:0]);
            gen_state_reg <= (gen_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (gen_fire) begin
            if (gen_is_last) gen_state_reg <= ST_DONE;
            else             gen_cnt_reg   <= gen_cnt_reg + LEN_ONE;
          end
        end
        default: gen_state_reg <= ST_IDLE;
      endcase
    end
  end

  assign gen_busy      = gen_run;
  assign gen_done      = (gen_state_reg == ST_DONE);
  assign m_axis.tvalid = gen_run;
  assign m_axis.tdata  = gen_word;
  assign m_axis.tkeep  = gen_is_last ? gen_keep_reg : 4'hF;
  assign m_axis.tlast  = gen_run && gen_is_last;
  assign m_axis.tid    = '0;
  assign m_axis.tuser  = '0;

  // ---------------- checker ----------------
  logic [1:0]            chk_state_reg;
  logic [LEN_W-1:0]      chk_cnt_reg;
  logic [LEN_W-1:0]      chk_last_reg;
  logic [3:0]            chk_keep_reg;
  logic [LEN_W-1:0]      err_cnt_reg;
  logic [LEN_W-1:0]      first_err_reg;
  logic                  len_err_reg;
  logic                  user_flag_reg;
  logic [31:0]           chk_word;
  logic                  chk_run;
  logic                  chk_is_last;
  logic                  chk_fire;
  logic                  chk_load;
  logic [3:0]            exp_keep;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic                  beat_bad;
  logic                  unused_tid;

  assign chk_run     = (chk_state_reg == ST_RUN);
  assign chk_is_last = (chk_cnt_reg == chk_last_reg);
  assign chk_fire    = chk_run && s_axis.tvalid;
  assign chk_load    = (chk_state_reg == ST_IDLE) && chk_start;
  assign exp_keep    = chk_is_last ? chk_keep_reg : 4'hF;

  // Byte lanes outside the expected tkeep are don't-care for the data compare.
  for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_mask
    assign keep_mask[gi*8 +: 8] = {8{exp_keep[gi]}};
  end

  assign beat_bad = (((s_axis.tdata ^ chk_word) & keep_mask) != '0) ||
                    (s_axis.tkeep != exp_keep);

  assign unused_tid = ^s_axis.tid;

  nfc_pattern_word u_chk_word (
    .clk  (nand_usr_clk),
    .rst  (nand_usr_rst),
    .load (chk_load),
    .seed (chk_seed),
    .adv  (chk_fire),
    .word (chk_word)
  );

  always_ff @(posedge nand_usr_clk) begin
    if (nand_usr_rst) begin
      chk_state_reg <= ST_IDLE;
      chk_cnt_reg   <= '0;
      chk_last_reg  <= '0;
      chk_keep_reg  <= '0;
      err_cnt_reg   <= '0;
      first_err_reg <= '1;
      len_err_reg   <= 1'b0;
      user_flag_reg <= 1'b0;
    end else begin
      case (chk_state_reg)
        ST_IDLE: begin
          if (chk_start) begin
            chk_cnt_reg   <= '0;
            chk_last_reg  <= (chk_len - LEN_ONE) >> 2;
            chk_keep_reg  <= keep_for_len(chk_len[1:0]);
            err_cnt_reg   <= '0;
            first_err_reg <= '1;
            len_err_reg   <= 1'b0;
            user_flag_reg <= 1'b0;
            chk_state_reg <= (chk_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (chk_fire) begin
            if (beat_bad) begin
              if (err_cnt_reg != '1)   err_cnt_reg   <= err_cnt_reg + LEN_ONE;
              if (first_err_reg == '1) first_err_reg <= chk_cnt_reg;
            end
            if (s_axis.tuser != '0) user_flag_reg <= 1'b1;
            // tlast must coincide exactly with the final expected beat;
            // either side ending first terminates the check.
            if (s_axis.tlast != chk_is_last) len_err_reg <= 1'b1;
            if (s_axis.tlast || chk_is_last) chk_state_reg <= ST_DONE;
            else                             chk_cnt_reg   <= chk_cnt_reg + LEN_ONE;
          end
        end
        default: chk_state_reg <= ST_IDLE;
      endcase
    end
  end

  assign s_axis.tready = chk_run;
  assign chk_busy      = chk_run;
  assign chk_done      = (chk_state_reg == ST_DONE);
  assign chk_err_cnt   = err_cnt_reg;
  assign chk_first_err = first_err_reg;
  assign chk_len_err   = len_err_reg;
  assign chk_user_flag = user_flag_reg;

endmodule

// File: tb/tb_nfc_axis_pattern_engine.sv
// Directed bench for nfc_axis_pattern_engine: generator, checker, loopback
// and mid-stream reset. Inputs change and outputs are sampled on the falling edge.
module tb_nfc_axis_pattern_engine;
  localparam int LEN_W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             gen_start;
  logic [31:0]      gen_seed;
  logic [LEN_W-1:0] gen_len;
  logic             gen_busy;
  logic             gen_done;
  logic             chk_start;
  logic [31:0]      chk_seed;
  logic [LEN_W-1:0] chk_len;
  logic             chk_busy;
  logic             chk_done;
  logic [LEN_W-1:0] chk_err_cnt;
  logic [LEN_W-1:0] chk_first_err;
  logic             chk_len_err;
  logic             chk_user_flag;

  nfc_axis_pattern_engine_if m_if ();
  nfc_axis_pattern_engine_if s_if ();

  int checks = 0;
  int errors = 0;

  nfc_axis_pattern_engine #(.DATA_WIDTH(32), .LEN_W(LEN_W)) dut (
    .nand_usr_clk  (clk),
    .nand_usr_rst  (rst),
    .gen_start     (gen_start),
    .gen_seed      (gen_seed),
    .gen_len       (gen_len),
    .gen_busy      (gen_busy),
    .gen_done      (gen_done),
    .m_axis        (m_if),
    .chk_start     (chk_start),
    .chk_seed      (chk_seed),
    .chk_len       (chk_len),
    .s_axis        (s_if),
    .chk_busy      (chk_busy),
    .chk_done      (chk_done),
    .chk_err_cnt   (chk_err_cnt),
    .chk_first_err (chk_first_err),
    .chk_len_err   (chk_len_err),
    .chk_user_flag (chk_user_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_s(input logic v, input logic [31:0] d, input logic [3:0] k,
                         input logic l, input logic [3:0] u);
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tuser  = u;
    s_if.tid    = 16'hABCD;
  endtask

  task automatic start_chk(input logic [31:0] seed, input logic [LEN_W-1:0] len);
    chk_seed  = seed;
    chk_len   = len;
    chk_start = 1'b1;
    tick();
    chk_start = 1'b0;
  endtask

  logic        seen_g, seen_c;
  int          nbeat;
  logic [31:0] exp_b0, exp_b1;

  initial begin
    rst = 1'b1; gen_start = 1'b0; gen_seed = '0; gen_len = '0;
    chk_start = 1'b0; chk_seed = '0; chk_len = '0;
    m_if.tready = 1'b0;
    drive_s(1'b0, 32'h0, 4'h0, 1'b0, 4'h0);
    repeat (3) tick();

    // ---- reset state ----
    check("rst_gen_busy", gen_busy, 0);
    check("rst_gen_done", gen_done, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_s_tready", s_if.tready, 0);
    check("rst_chk_busy", chk_busy, 0);
    check("rst_chk_done", chk_done, 0);
    check("rst_err_cnt", chk_err_cnt, 0);
    check("rst_first_err", chk_first_err, 32'h00FF_FFFF);
    check("rst_len_err", chk_len_err, 0);
    check("rst_user_flag", chk_user_flag, 0);
    rst = 1'b0;
    tick();

    // ---- 1: gen seed 0x10, len 8, tready held high ----
    gen_seed = 32'h10; gen_len = 24'd8; gen_start = 1'b1; m_if.tready = 1'b1;
    tick();
    gen_start = 1'b0;
`ifndef PATTERN_LFSR_EN
    check("t1_b0_data", m_if.tdata, 32'h10);
`endif
    check("t1_b0_valid", m_if.tvalid, 1);
    check("t1_b0_keep", m_if.tkeep, 4'hF);
    check("t1_b0_last", m_if.tlast, 0);
    check("t1_busy", gen_busy, 1);
    tick();
`ifndef PATTERN_LFSR_EN
    check("t1_b1_data", m_if.tdata, 32'h11);
`endif
    check("t1_b1_keep", m_if.tkeep, 4'hF);
    check("t1_b1_last", m_if.tlast, 1);
    tick();
    check("t1_done", gen_done, 1);
    check("t1_busy_drop", gen_busy, 0);
    check("t1_valid_drop", m_if.tvalid, 0);
    tick();
    check("t1_done_pulse", gen_done, 0);

    // ---- 2: gen len 6 with tready toggling ----
    gen_seed = 32'h100; gen_len = 24'd6; gen_start = 1'b1; m_if.tready = 1'b0;
    tick();
    gen_start = 1'b0;
    check("t2_b0_valid", m_if.tvalid, 1);
    tick();
`ifndef PATTERN_LFSR_EN
    check("t2_b0_hold", m_if.tdata, 32'h100);
`endif
    check("t2_b0_hold_last", m_if.tlast, 0);
    m_if.tready = 1'b1;
    tick();
    m_if.tready = 1'b0;
`ifndef PATTERN_LFSR_EN
    check("t2_b1_data", m_if.tdata, 32'h101);
`endif
    check("t2_b1_keep", m_if.tkeep, 4'b0011);
    check("t2_b1_last", m_if.tlast, 1);
    tick();
`ifndef PATTERN_LFSR_EN
    check("t2_b1_hold", m_if.tdata, 32'h101);
`endif
    check("t2_b1_hold_keep", m_if.tkeep, 4'b0011);
    check("t2_no_done", gen_done, 0);
    m_if.tready = 1'b1;
    tick();
    check("t2_done", gen_done, 1);
    m_if.tready = 1'b0;
    tick();

    // ---- 3: checker clean pass, seed 0x10 len 8 (counter pattern) ----
`ifndef PATTERN_LFSR_EN
    start_chk(32'h10, 24'd8);
    check("t3_tready", s_if.tready, 1);
    check("t3_busy", chk_busy, 1);
    drive_s(1'b1, 32'h10, 4'hF, 1'b0, 4'h0); tick();
    drive_s(1'b1, 32'h11, 4'hF, 1'b1, 4'h0); tick();
    drive_s(1'b0, 32'h0, 4'h0, 1'b0, 4'h0);
    check("t3_done", chk_done, 1);
    check("t3_err_cnt", chk_err_cnt, 0);
    check("t3_first_err", chk_first_err, 32'h00FF_FFFF);
    check("t3_len_err", chk_len_err, 0);
    check("t3_tready_drop", s_if.tready, 0);
    tick();
    check("t3_done_pulse", chk_done, 0);

    // ---- 4a: len 16, beat 2 corrupted, tuser on beat 0 ----
    start_chk(32'h20, 24'd16);
    drive_s(1'b1, 32'h20, 4'hF, 1'b0, 4'h2); tick();
    drive_s(1'b1, 32'h21, 4'hF, 1'b0, 4'h0); tick();
    drive_s(1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'h0); tick();
    drive_s(1'b1, 32'h23, 4'hF, 1'b1, 4'h0); tick();
    drive_s(1'b0, 32'h0, 4'h0, 1'b0, 4'h0);
    check("t4a_done", chk_done, 1);
    check("t4a_err_cnt", chk_err_cnt, 1);
    check("t4a_first_err", chk_first_err, 2);
    check("t4a_len_err", chk_len_err, 0);
    check("t4a_user_flag", chk_user_flag, 1);
    tick();

    // ---- 4b: len 16, early tlast on beat 1 ----
    start_chk(32'h30, 24'd16);
    drive_s(1'b1, 32'h30, 4'hF, 1'b0, 4'h0); tick();
    drive_s(1'b1, 32'h31, 4'hF, 1'b1, 4'h0); tick();
    drive_s(1'b0, 32'h0, 4'h0, 1'b0, 4'h0);
    check("t4b_done", chk_done, 1);
    check("t4b_len_err", chk_len_err, 1);
    check("t4b_err_cnt", chk_err_cnt, 0);
    check("t4b_user_clr", chk_user_flag, 0);
    tick();

    // ---- 4c: len 4, final beat without tlast ----
    start_chk(32'h60, 24'd4);
    drive_s(1'b1, 32'h60, 4'hF, 1'b0, 4'h0); tick();
    check("t4c_done", chk_done, 1);
    check("t4c_len_err", chk_len_err, 1);
    check("t4c_tready", s_if.tready, 0);
    drive_s(1'b0, 32'h0, 4'h0, 1'b0, 4'h0);
    tick();

    // ---- 4d: len 6, masked lanes ignored on partial final beat ----
    start_chk(32'h40, 24'd6);
    drive_s(1'b1, 32'h40, 4'hF, 1'b0, 4'h0); tick();
    drive_s(1'b1, 32'hFFFF_0041, 4'b0011, 1'b1, 4'h0); tick();
    drive_s(1'b0, 32'h0, 4'h0, 1'b0, 4'h0);
    check("t4d_err_cnt", chk_err_cnt, 0);
    check("t4d_len_err", chk_len_err, 0);
    tick();

    // ---- 4e: len 6, wrong tkeep on final beat ----
    start_chk(32'h40, 24'd6);
    drive_s(1'b1, 32'h40, 4'hF, 1'b0, 4'h0); tick();
    drive_s(1'b1, 32'h0000_0041, 4'hF, 1'b1, 4'h0); tick();
    drive_s(1'b0, 32'h0, 4'h0, 1'b0, 4'h0);
    check("t4e_err_cnt", chk_err_cnt, 1);
    check("t4e_first_err", chk_first_err, 1);
    tick();
`endif

    // ---- 4f: chk_len 0 finishes immediately ----
    start_chk(32'h0, 24'd0);
    check("t4f_done", chk_done, 1);
    check("t4f_tready", s_if.tready, 0);
    tick();

    // ---- 5: loopback generator -> checker, seed 0, len 16 ----
`ifdef PATTERN_LFSR_EN
    exp_b0 = 32'h0000_0001; exp_b1 = 32'h8020_0003;
`else
    exp_b0 = 32'h0000_0000; exp_b1 = 32'h0000_0001;
`endif
    gen_seed = 32'h0; gen_len = 24'd16; gen_start = 1'b1;
    chk_seed = 32'h0; chk_len = 24'd16; chk_start = 1'b1;
    tick();
    gen_start = 1'b0; chk_start = 1'b0;
    seen_g = 1'b0; seen_c = 1'b0; nbeat = 0;
    for (int c = 0; c < 40 && !(seen_g && seen_c); c++) begin
      s_if.tvalid = m_if.tvalid;
      s_if.tdata  = m_if.tdata;
      s_if.tkeep  = m_if.tkeep;
      s_if.tlast  = m_if.tlast;
      s_if.tuser  = 4'h0;
      m_if.tready = s_if.tready;
      if (m_if.tvalid && s_if.tready) begin
        if (nbeat == 0) check("t5_beat0", m_if.tdata, exp_b0);
        if (nbeat == 1) check("t5_beat1", m_if.tdata, exp_b1);
        nbeat++;
      end
      tick();
      if (gen_done) seen_g = 1'b1;
      if (chk_done) seen_c = 1'b1;
    end
    check("t5_both_done", {seen_g, seen_c}, 2'b11);
    check("t5_beats", nbeat, 4);
    check("t5_err_cnt", chk_err_cnt, 0);
    check("t5_len_err", chk_len_err, 0);
    check("t5_first_err", chk_first_err, 32'h00FF_FFFF);
    drive_s(1'b0, 32'h0, 4'h0, 1'b0, 4'h0);
    tick();

    // ---- 6: reset at beat 3 of len 64, then restart ----
    gen_seed = 32'h50; gen_len = 24'd64; gen_start = 1'b1; m_if.tready = 1'b1;
    tick();
    gen_start = 1'b0;
    repeat (3) tick();
`ifndef PATTERN_LFSR_EN
    check("t6_beat3", m_if.tdata, 32'h53);
`endif
    check("t6_valid_pre", m_if.tvalid, 1);
    rst = 1'b1;
    tick();
    check("t6_valid_rst", m_if.tvalid, 0);
    check("t6_busy_rst", gen_busy, 0);
    check("t6_done_rst", gen_done, 0);
    rst = 1'b0;
    tick();
    check("t6_done_after", gen_done, 0);
    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    check("t6_restart_b0", m_if.tdata, 32'h50);
    check("t6_restart_last", m_if.tlast, 0);
    seen_g = 1'b0; nbeat = 0;
    for (int c = 0; c < 40 && !seen_g; c++) begin
      if (m_if.tvalid) nbeat++;
      tick();
      if (gen_done) seen_g = 1'b1;
    end
    check("t6_restart_done", seen_g, 1);
    check("t6_restart_beats", nbeat, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
